trava_automatica: RTL and testbench

- Parametrised auto-lock controller for the fechadura operational path; successor to the fixed auto-lock timer logic inside operacional.
- Once the lock is released, counts whole seconds with the door closed and re-engages the tranca after a configurable time.
- Adds a door-ajar alarm (bip after a configurable open time) and a seconds-remaining output for the display.
- Instantiated by operacional; the unlock request is driven by the internal button or a valid password.

---
 rtl/trava_automatica.sv | 193 +++++++++++++++++++
 tb/tb_trava_automatica.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trava_automatica.sv
// trava_automatica: auto-lock controller for the fechadura operational path.
// Counts whole seconds with the door closed after an unlock and re-engages the
// tranca after timer_trancamento seconds. Counts door-open seconds and raises
// bip after timer_bip seconds. restante shows the seconds left before auto-lock.
// Optional feature macro: BIP_INTERMITENTE_EN. When it is defined, bip blinks in
// ALARME, and each phase lasts CICLOS_POR_SEGUNDO/2 cycles.
module trava_automatica #(
    parameter int CICLOS_POR_SEGUNDO = 1000,
    parameter int TIMER_W            = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sensor_contato,
    input  logic               destrava_req,
    input  logic               trava_req,
    input  logic [TIMER_W-1:0] timer_trancamento,
    input  logic [TIMER_W-1:0] timer_bip,
    output logic               tranca,
    output logic               bip,
    output logic [TIMER_W-1:0] restante,
    output logic [1:0]         estado
);

    localparam int               PRE_W   = $clog2(CICLOS_POR_SEGUNDO);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CICLOS_POR_SEGUNDO - 1);
    localparam logic [TIMER_W-1:0] SEG_MAX = '1;
`ifdef BIP_INTERMITENTE_EN
    localparam logic [PRE_W-1:0] HALF_MAX = PRE_W'(CICLOS_POR_SEGUNDO / 2 - 1);
`endif

    typedef enum logic [1:0] {
        TRAVADA          = 2'd0,
        FECHADA_CONTANDO = 2'd1,
        ABERTA           = 2'd2,
        ALARME           = 2'd3
    } estado_t;

    estado_t            st, st_n;
    logic [PRE_W-1:0]   prescaler, pre_n;
    logic [TIMER_W-1:0] segundos, seg_n;
    logic [TIMER_W-1:0] lat, lat_n;
    logic [TIMER_W-1:0] rest_n;
    logic               tranca_n, bip_n;

    logic               tick;
    logic [TIMER_W-1:0] seg_inc;

    // The prescaler wrap marks one whole second. The seconds counter saturates
    // and does not wrap.
    assign tick    = (prescaler == PRE_MAX);
    assign seg_inc = (segundos == SEG_MAX) ? segundos : segundos + TIMER_W'(1);
    assign estado  = st;

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= TRAVADA;
            prescaler <= '0;
            segundos  <= '0;
            lat       <= '0;
            tranca    <= 1'b1;
            bip       <= 1'b0;
            restante  <= '0;
        end else begin
            st        <= st_n;
            prescaler <= pre_n;
            segundos  <= seg_n;
            lat       <= lat_n;
            tranca    <= tranca_n;
            bip       <= bip_n;
            restante  <= rest_n;
        end
    end

    // Next state and outputs. Same-cycle priority, from highest to lowest:
    // door open, trava_req, destrava_req, timer expiry.
    always_comb begin
        st_n     = st;
        pre_n    = prescaler;
        seg_n    = segundos;
        lat_n    = lat;
        tranca_n = tranca;
        bip_n    = bip;
        rest_n   = restante;
        case (st)
            TRAVADA: begin
                tranca_n = 1'b1;
                bip_n    = 1'b0;
                rest_n   = '0;
                if (destrava_req) begin
                    pre_n    = '0;
                    seg_n    = '0;
                    tranca_n = 1'b0;
                    if (sensor_contato) begin
                        st_n   = FECHADA_CONTANDO;
                        lat_n  = timer_trancamento;
                        rest_n = timer_trancamento;
                    end else begin
                        st_n  = ABERTA;
                        lat_n = timer_bip;
                    end
                end
            end
            FECHADA_CONTANDO: begin
                if (!sensor_contato) begin
                    // An open door discards the count. The count does not pause.
                    st_n   = ABERTA;
                    lat_n  = timer_bip;
                    pre_n  = '0;
                    seg_n  = '0;
                    rest_n = '0;
                end else if (trava_req) begin
                    st_n     = TRAVADA;
                    tranca_n = 1'b1;
                    pre_n    = '0;
                    seg_n    = '0;
                    rest_n   = '0;
                end else if (destrava_req) begin
                    lat_n  = timer_trancamento;
                    pre_n  = '0;
                    seg_n  = '0;
                    rest_n = timer_trancamento;
                end else if (tick) begin
                    pre_n = '0;
                    seg_n = seg_inc;
                    if (restante != '0)
                        rest_n = restante - TIMER_W'(1);
                    // When lat is 0, auto-lock is off and the state never expires.
                    if (lat != '0 && seg_inc == lat) begin
                        st_n     = TRAVADA;
                        tranca_n = 1'b1;
                        seg_n    = '0;
                        rest_n   = '0;
                    end
                end else begin
                    pre_n = prescaler + PRE_W'(1);
                end
            end
            ABERTA: begin
                if (sensor_contato) begin
                    st_n   = FECHADA_CONTANDO;
                    lat_n  = timer_trancamento;
                    rest_n = timer_trancamento;
                    pre_n  = '0;
                    seg_n  = '0;
                end else if (destrava_req) begin
                    lat_n = timer_bip;
                    pre_n = '0;
                    seg_n = '0;
                end else if (tick) begin
                    pre_n = '0;
                    seg_n = seg_inc;
                    if (lat != '0 && seg_inc == lat) begin
                        st_n  = ALARME;
                        bip_n = 1'b1;
                        seg_n = '0;
                    end
                end else begin
                    pre_n = prescaler + PRE_W'(1);
                end
            end
            ALARME: begin
                if (sensor_contato) begin
                    st_n   = FECHADA_CONTANDO;
                    lat_n  = timer_trancamento;
                    rest_n = timer_trancamento;
                    pre_n  = '0;
                    seg_n  = '0;
                    bip_n  = 1'b0;
                end else if (destrava_req) begin
                    lat_n = timer_bip;
                    pre_n = '0;
                    seg_n = '0;
                    bip_n = 1'b1;
                end else begin
`ifdef BIP_INTERMITENTE_EN
                    // Blink: the prescaler times half-second phases. The first phase is high.
                    if (prescaler == HALF_MAX) begin
                        pre_n = '0;
                        bip_n = ~bip;
                    end else begin
                        pre_n = prescaler + PRE_W'(1);
                    end
`else
                    bip_n = 1'b1;
`endif
                end
            end
            default: st_n = TRAVADA;
        endcase
    end

endmodule

// File: tb/tb_trava_automatica.sv
// Self-checking bench for trava_automatica (CICLOS_POR_SEGUNDO=10, TIMER_W=6).
// The reference model tracks the state and the cycles spent since the last state
// entry. It derives the seconds and the outputs from that cycle count.
module tb_trava_automatica;
    localparam int C = 10;
    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sensor = 1'b1, dreq = 1'b0, treq = 1'b0;
    logic [W-1:0] tt = '0, tb = '0;
    logic         tranca, bip;
    logic [W-1:0] restante;
    logic [1:0]   estado;

    int vectors = 0;
    int miscompares = 0;

    // model: state (0..3), cycles since entry, latched timer
    int m_st = 0, m_t = 0, m_lat = 0;

    trava_automatica #(.CICLOS_POR_SEGUNDO(C), .TIMER_W(W)) dut (
        .clk(clk), .rst(rst), .sensor_contato(sensor), .destrava_req(dreq),
        .trava_req(treq), .timer_trancamento(tt), .timer_bip(tb),
        .tranca(tranca), .bip(bip), .restante(restante), .estado(estado)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] exp_vec();  // {estado, tranca, bip, restante}
        logic b;
        int   r;
        b = (m_st == 3);
`ifdef BIP_INTERMITENTE_EN
        if (m_st == 3) b = ((m_t / (C / 2)) % 2) == 0;
`endif
        r = (m_st == 1 && m_lat != 0) ? m_lat - m_t / C : 0;
        return {2'(m_st), (m_st == 0), b, W'(r)};
    endfunction

    function automatic logic [9:0] act_vec();
        return {estado, tranca, bip, restante};
    endfunction

    task automatic enter_fc(); m_st = 1; m_t = 0; m_lat = int'(tt); endtask
    task automatic enter_ab(); m_st = 2; m_t = 0; m_lat = int'(tb); endtask

    // One clock edge: the model advances with the inputs sampled at that edge.
    task automatic step();
        @(posedge clk);
        case (m_st)
            0: if (dreq) begin if (sensor) enter_fc(); else enter_ab(); end
            1: if (!sensor) enter_ab();
               else if (treq) m_st = 0;
               else if (dreq) enter_fc();
               else begin
                   m_t++;
                   if (m_lat != 0 && m_t == m_lat * C) m_st = 0;
               end
            2: if (sensor) enter_fc();
               else if (dreq) enter_ab();
               else begin
                   m_t++;
                   if (m_lat != 0 && m_t == m_lat * C) begin m_st = 3; m_t = 0; end
               end
            default: if (sensor) enter_fc();
                     else if (dreq) m_t = 0;
                     else m_t++;
        endcase
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        vectors++;
        if (act_vec() !== 10'b00_1_0_000000) begin
            miscompares++;
            $display("FAIL reset_init: got %h want %h", act_vec(), 10'b00_1_0_000000);
        end
        @(negedge clk); rst = 1'b1;
        m_st = 0; m_t = 0; m_lat = 0;
        // unlock, count a while, then reset asynchronously in mid-cycle
        tt = 6'd5; sensor = 1'b1; dreq = 1'b1; step(); dreq = 1'b0;
        repeat (23) step();
        vectors++;
        if (act_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_precount: got %h want %h", act_vec(), exp_vec());
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (act_vec() !== 10'b00_1_0_000000) begin
            miscompares++;
            $display("FAIL reset_async: got %h want %h", act_vec(), 10'b00_1_0_000000);
        end
        m_st = 0; m_t = 0; m_lat = 0;
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_autolock();
        tt = 6'd5; sensor = 1'b1; dreq = 1'b1; step(); dreq = 1'b0;
        vectors++;
        if (tranca !== 1'b0 || restante !== 6'd5) begin
            miscompares++;
            $display("FAIL autolock_entry: got tranca=%b rest=%0d want 0/5", tranca, restante);
        end
        for (int k = 1; k <= 50; k++) begin
            step();
            vectors++;
            if (act_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL autolock_k%0d: got %h want %h", k, act_vec(), exp_vec());
            end
            if (k % 10 == 0 && k < 50) begin
                vectors++;
                if (restante !== W'(5 - k / 10)) begin
                    miscompares++;
                    $display("FAIL autolock_rest_k%0d: got %0d want %0d", k, restante, 5 - k / 10);
                end
            end
            if (k == 37 || k == 49 || k == 50) begin
                vectors++;
                if (tranca !== (k == 50)) begin
                    miscompares++;
                    $display("FAIL autolock_tranca_k%0d: got %b want %b", k, tranca, k == 50);
                end
            end
        end
    endtask

    task automatic test_interrupt();
        tt = 6'd5; tb = 6'd3; sensor = 1'b1; dreq = 1'b1; step(); dreq = 1'b0;
        repeat (30) step();
        sensor = 1'b0; step(); step();
        sensor = 1'b1; step();
        for (int k = 1; k <= 50; k++) begin
            step();
            vectors++;
            if (act_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL interrupt_k%0d: got %h want %h", k, act_vec(), exp_vec());
            end
            if (k == 49 || k == 50) begin
                vectors++;
                if (tranca !== (k == 50)) begin
                    miscompares++;
                    $display("FAIL interrupt_tranca_k%0d: got %b want %b", k, tranca, k == 50);
                end
            end
        end
    endtask

    task automatic test_alarm();
        logic exp35;
        tt = 6'd4; tb = 6'd3; sensor = 1'b0; dreq = 1'b1; step(); dreq = 1'b0;
        for (int k = 1; k <= 37; k++) begin
            step();
            vectors++;
            if (act_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL alarm_k%0d: got %h want %h", k, act_vec(), exp_vec());
            end
            if (k == 29 || k == 30) begin
                vectors++;
                if (bip !== (k == 30)) begin
                    miscompares++;
                    $display("FAIL alarm_bip_k%0d: got %b want %b", k, bip, k == 30);
                end
            end
            if (k == 35) begin
`ifdef BIP_INTERMITENTE_EN
                exp35 = 1'b0;
`else
                exp35 = 1'b1;
`endif
                vectors++;
                if (bip !== exp35) begin
                    miscompares++;
                    $display("FAIL alarm_bip_phase: got %b want %b", bip, exp35);
                end
            end
        end
        sensor = 1'b1; step();
        vectors++;
        if (bip !== 1'b0 || estado !== 2'd1) begin
            miscompares++;
            $display("FAIL alarm_close: got bip=%b estado=%0d want 0/1", bip, estado);
        end
        treq = 1'b1; step(); treq = 1'b0;
    endtask

    task automatic test_simultaneous();
        tt = 6'd2; sensor = 1'b1; dreq = 1'b1; step(); dreq = 1'b0;
        repeat (19) step();
        sensor = 1'b0; step();
        vectors++;
        if (estado !== 2'd2 || tranca !== 1'b0 || act_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL simul_expiry_open: got %h want estado=2 tranca=0 (%h)", act_vec(), exp_vec());
        end
        treq = 1'b1; step(); treq = 1'b0;
        vectors++;
        if (tranca !== 1'b0 || estado !== 2'd2) begin
            miscompares++;
            $display("FAIL simul_trava_open: got tranca=%b estado=%0d want 0/2", tranca, estado);
        end
        sensor = 1'b1; step();
        treq = 1'b1; step(); treq = 1'b0;
        vectors++;
        if (act_vec() !== 10'b00_1_0_000000) begin
            miscompares++;
            $display("FAIL simul_trava_closed: got %h want %h", act_vec(), 10'b00_1_0_000000);
        end
    endtask

    task automatic test_disabled();
        tt = 6'd0; tb = 6'd0; sensor = 1'b1; dreq = 1'b1; step(); dreq = 1'b0;
        repeat (1000) step();
        vectors++;
        if (tranca !== 1'b0 || restante !== 6'd0 || estado !== 2'd1) begin
            miscompares++;
            $display("FAIL disabled_lock: got tranca=%b rest=%0d estado=%0d want 0/0/1", tranca, restante, estado);
        end
        sensor = 1'b0; step();
        repeat (1000) step();
        vectors++;
        if (bip !== 1'b0 || estado !== 2'd2) begin
            miscompares++;
            $display("FAIL disabled_bip: got bip=%b estado=%0d want 0/2", bip, estado);
        end
        sensor = 1'b1; step();
        treq = 1'b1; step(); treq = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 29) == 0) sensor = ~sensor;
            dreq = ($urandom_range(0, 19) == 0);
            treq = ($urandom_range(0, 24) == 0);
            tt   = W'($urandom_range(0, 3));
            tb   = W'($urandom_range(0, 3));
            step();
            vectors++;
            if (act_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random_k%0d: got %h want %h", k, act_vec(), exp_vec());
            end
        end
        dreq = 1'b0; treq = 1'b0;
    endtask

    initial begin
        test_reset();
        test_autolock();
        test_interrupt();
        test_alarm();
        test_simultaneous();
        test_disabled();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
